// File: rtl/temp_pkg.sv
// Shared types and constants for the temperature sample-and-average path.
// Temperatures are signed 13-bit values in 1/16 degC steps.
package temp_pkg;

  localparam int TEMP_W         = 13;
  localparam int DECI_W         = 16;
  localparam int AVG_DEPTH_LOG2 = 3;
  localparam int AVG_DEPTH      = 1 << AVG_DEPTH_LOG2;
  localparam int SUM_W          = 16;

  typedef logic signed [TEMP_W-1:0] temp_t;

  typedef enum logic {
    EMPTY = 1'b0,
    RUN   = 1'b1
  } state_t;

  // |raw| * 10 / 16, with a 17-bit intermediate so that -4096 maps to 2560
  function automatic logic [DECI_W-1:0] raw_to_deci(input temp_t raw);
    logic [TEMP_W+3:0] ext;
    logic [TEMP_W+3:0] mag;
    logic [TEMP_W+3:0] prod;
    ext  = {{4{raw[TEMP_W-1]}}, raw};
    mag  = raw[TEMP_W-1] ? (17'd0 - ext) : ext;
    prod = mag * 17'd10;
    return {3'b000, prod[TEMP_W+3:4]};
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running sample tick: one-cycle pulse on the terminal count of a
// 0..SAMPLE_CYCLES-1 counter.
module tick_gen #(
  parameter int SAMPLE_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick_o
);

  localparam int              CNT_W = $clog2(SAMPLE_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // Wrapping sample counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/temp_avg_filter.sv
// 8-deep moving average of sensor temperature with min/max tracking and
// conversion to tenths of a degree; upd pulses 3 cycles after each accepted tick.
module temp_avg_filter
  import temp_pkg::*;
#(
  parameter int SAMPLE_CYCLES = 100_000_000,
  parameter int MISS_LIMIT    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [TEMP_W-1:0] temp_in,
  input  logic              temp_rdy,
  input  logic              temp_err,
  input  logic              clear_minmax,
  output logic [DECI_W-1:0] avg_deci,
  output logic              avg_neg,
  output logic [TEMP_W-1:0] avg_raw,
  output logic [TEMP_W-1:0] min_raw,
  output logic [TEMP_W-1:0] max_raw,
  output logic              valid,
  output logic              upd
);

  localparam logic [3:0] MISS_LAST = 4'(MISS_LIMIT);

  logic tick_s;
  logic accept_s;
  temp_t sample_s;
  logic signed [SUM_W-1:0] sum_next_s;

  state_t                    state_q;
  temp_t                     ring_q [AVG_DEPTH];
  logic signed [SUM_W-1:0]   sum_q;
  logic [AVG_DEPTH_LOG2-1:0] wr_ptr_q;
  logic [3:0]                miss_q;
  logic                      s1_q;
  logic                      first_q;
  logic                      valid_q;

  temp_t             avg_d, avg_q;
  logic [DECI_W-1:0] deci_d, deci_q;
  logic              neg_q;
  logic              s2_q;

  temp_t min_q, max_q;
  logic  upd_q;
  logic  clr_pend_q;
  logic  clr_now_s;

  tick_gen #(.SAMPLE_CYCLES(SAMPLE_CYCLES)) u_tick_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .tick_o (tick_s)
  );

  assign sample_s   = temp_t'(temp_in);
  assign accept_s   = tick_s & temp_rdy & ~temp_err;
  assign sum_next_s = sum_q
                    - {{(SUM_W-TEMP_W){ring_q[wr_ptr_q][TEMP_W-1]}}, ring_q[wr_ptr_q]}
                    + {{(SUM_W-TEMP_W){sample_s[TEMP_W-1]}}, sample_s};

  // Fill/run state machine owning the ring, running sum and stale detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= EMPTY;
      for (int i = 0; i < AVG_DEPTH; i++) ring_q[i] <= '0;
      sum_q    <= '0;
      wr_ptr_q <= '0;
      miss_q   <= '0;
      s1_q     <= 1'b0;
      first_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      s1_q <= 1'b0;
      if (s2_q) begin
        first_q <= 1'b0;
        valid_q <= 1'b1;
      end
      case (state_q)
        EMPTY: begin
          if (accept_s) begin
            for (int i = 0; i < AVG_DEPTH; i++) ring_q[i] <= sample_s;
            sum_q    <= {sample_s, 3'b000};
            wr_ptr_q <= '0;
            miss_q   <= '0;
            s1_q     <= 1'b1;
            first_q  <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (accept_s) begin
            ring_q[wr_ptr_q] <= sample_s;
            sum_q    <= sum_next_s;
            wr_ptr_q <= wr_ptr_q + 3'd1;
            miss_q   <= '0;
            s1_q     <= 1'b1;
          end else if (tick_s) begin
            if (miss_q + 4'd1 == MISS_LAST) begin
              miss_q  <= '0;
              valid_q <= 1'b0;
              state_q <= EMPTY;
            end else begin
              miss_q <= miss_q + 4'd1;
            end
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign avg_d  = sum_q[SUM_W-1:3];
  assign deci_d = raw_to_deci(avg_d);

  // Average and display conversion stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avg_q  <= '0;
      deci_q <= '0;
      neg_q  <= 1'b0;
      s2_q   <= 1'b0;
    end else begin
      s2_q <= s1_q;
      if (s1_q) begin
        avg_q  <= avg_d;
        deci_q <= deci_d;
        neg_q  <= avg_d[TEMP_W-1];
      end
    end
  end

  // A clear seen on the same edge that loads min/max takes effect immediately
  assign clr_now_s = clr_pend_q | clear_minmax;

  // Min/max tracking and result strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      min_q      <= '0;
      max_q      <= '0;
      upd_q      <= 1'b0;
      clr_pend_q <= 1'b0;
    end else begin
      upd_q <= s2_q;
      if (s2_q) begin
        clr_pend_q <= 1'b0;
        if (first_q || clr_now_s) begin
          min_q <= avg_q;
          max_q <= avg_q;
        end else begin
          if (avg_q < min_q) min_q <= avg_q;
          if (avg_q > max_q) max_q <= avg_q;
        end
      end else if (clear_minmax) begin
        clr_pend_q <= 1'b1;
      end
    end
  end

  assign avg_raw  = avg_q;
  assign avg_deci = deci_q;
  assign avg_neg  = neg_q;
  assign min_raw  = min_q;
  assign max_raw  = max_q;
  assign valid    = valid_q;
  assign upd      = upd_q;

endmodule

// File: tb/tb_temp_avg_filter.sv
// Randomized, self-checking bench for temp_avg_filter against a behavioural
// model that keeps the last eight samples and recomputes the average directly.
module tb_temp_avg_filter;

  localparam int SC = 16;
  localparam int ML = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [12:0] temp_in = '0;
  logic        temp_rdy = 1'b0;
  logic        temp_err = 1'b0;
  logic        clear_minmax = 1'b0;
  logic [15:0] avg_deci;
  logic        avg_neg;
  logic [12:0] avg_raw, min_raw, max_raw;
  logic        valid, upd;

  int checks = 0;
  int errors = 0;
  int tb_cnt;

  temp_avg_filter #(.SAMPLE_CYCLES(SC), .MISS_LIMIT(ML)) dut (
    .clk(clk), .reset_n(reset_n), .temp_in(temp_in), .temp_rdy(temp_rdy),
    .temp_err(temp_err), .clear_minmax(clear_minmax), .avg_deci(avg_deci),
    .avg_neg(avg_neg), .avg_raw(avg_raw), .min_raw(min_raw), .max_raw(max_raw),
    .valid(valid), .upd(upd)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_cnt <= 0;
    else          tb_cnt <= (tb_cnt == SC - 1) ? 0 : tb_cnt + 1;
  end

  int ring_m [8];
  bit run_m, first_m, pend_m, valid_m, neg_m;
  int wr_m, miss_m, avg_m, deci_m, min_m, max_m;

  int          obs_upd_sig;
  logic [56:0] obs_vec;
  bit          exp_upd;

  function automatic int fdiv8(input int x);
    return (x >= 0) ? x / 8 : -((-x + 7) / 8);
  endfunction

  function automatic void model_reset();
    foreach (ring_m[i]) ring_m[i] = 0;
    run_m = 0; first_m = 0; pend_m = 0; valid_m = 0; neg_m = 0;
    wr_m = 0; miss_m = 0; avg_m = 0; deci_m = 0; min_m = 0; max_m = 0;
  endfunction

  function automatic bit model_tick(input int s, input bit acc);
    int sum;
    if (acc) begin
      if (!run_m) begin
        foreach (ring_m[i]) ring_m[i] = s;
        wr_m = 0; run_m = 1; first_m = 1;
      end else begin
        ring_m[wr_m] = s;
        wr_m = (wr_m + 1) % 8;
      end
      miss_m = 0;
      sum = 0;
      foreach (ring_m[i]) sum += ring_m[i];
      avg_m  = fdiv8(sum);
      neg_m  = (avg_m < 0);
      deci_m = ((avg_m < 0 ? -avg_m : avg_m) * 10) / 16;
      if (first_m || pend_m) begin
        min_m = avg_m; max_m = avg_m;
      end else begin
        if (avg_m < min_m) min_m = avg_m;
        if (avg_m > max_m) max_m = avg_m;
      end
      first_m = 0; pend_m = 0; valid_m = 1;
      return 1'b1;
    end
    if (run_m) begin
      miss_m++;
      if (miss_m == ML) begin
        run_m = 0; valid_m = 0; miss_m = 0;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [56:0] exp_vec();
    return {13'(avg_m), 16'(deci_m), neg_m, 13'(min_m), 13'(max_m), valid_m};
  endfunction

  function automatic logic [56:0] dut_vec();
    return {avg_raw, avg_deci, avg_neg, min_raw, max_raw, valid};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; temp_rdy = 1'b0; temp_err = 1'b0; clear_minmax = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // Drive one tick and record upd per cycle T1..T4 plus the outputs seen at T3
  task automatic run_tick(input logic [12:0] s, input bit rdy, input bit err, input int clr_at);
    int guard;
    @(negedge clk);
    temp_in = s; temp_rdy = rdy; temp_err = err;
    guard = 0;
    while (tb_cnt != SC - 1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      checks++; errors++;
      $display("FAIL tick_wait: tick not reached, counter %0d required %0d", tb_cnt, SC - 1);
    end
    if (clr_at == 1 || clr_at == 2) pend_m = 1;
    exp_upd = model_tick(int'($signed(s)), rdy && !err);
    obs_upd_sig = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      clear_minmax = (k == clr_at);
      if (upd === 1'b1) obs_upd_sig += (k == 3) ? 1 : 10;
      if (k == 3) obs_vec = dut_vec();
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_minmax = 1'b1;
    @(negedge clk);
    clear_minmax = 1'b0;
    pend_m = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_vec() !== exp_vec() || upd !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %h upd %b expected %h upd 0", dut_vec(), upd, exp_vec());
    end
    repeat (SC + 2) @(negedge clk);
    checks++;
    if (dut_vec() !== exp_vec() || upd !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got %h upd %b expected %h upd 0", dut_vec(), upd, exp_vec());
    end
  endtask

  task automatic test_fill_step();
    logic [12:0] seq [9];
    seq[0] = 13'h190;
    for (int i = 1; i < 9; i++) seq[i] = 13'h1A0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      run_tick(seq[i], 1'b1, 1'b0, 0);
      checks++;
      if (obs_upd_sig !== (exp_upd ? 1 : 0) || obs_vec !== exp_vec()) begin
        errors++;
        $display("FAIL fill_step[%0d]: upd %0d out %h expected upd %0d out %h",
                 i, obs_upd_sig, obs_vec, exp_upd ? 1 : 0, exp_vec());
      end
    end
  endtask

  task automatic test_negative();
    do_reset();
    run_tick(13'h1FF0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs_upd_sig !== 1 || obs_vec !== exp_vec()) begin
        errors++;
        $display("FAIL negative[%0d]: upd %0d out %h expected upd 1 out %h",
                 i, obs_upd_sig, obs_vec, exp_vec());
      end
      if (i < 8) run_tick(13'h0020, 1'b1, 1'b0, 0);
    end
  endtask

  task automatic test_stale();
    bit rdy_t [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit err_t [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    run_tick(13'h0300, 1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) run_tick(13'h0777, rdy_t[i], err_t[i], 0);
      else       run_tick(13'h00A0, 1'b1, 1'b0, 0);
      checks++;
      if (obs_upd_sig !== (exp_upd ? 1 : 0) || obs_vec !== exp_vec()) begin
        errors++;
        $display("FAIL stale[%0d]: upd %0d out %h expected upd %0d out %h",
                 i, obs_upd_sig, obs_vec, exp_upd ? 1 : 0, exp_vec());
      end
    end
  endtask

  task automatic test_clear();
    for (int mode = 0; mode < 2; mode++) begin
      do_reset();
      run_tick(13'h190, 1'b1, 1'b0, 0);
      run_tick(13'h1A0, 1'b1, 1'b0, 0);
      if (mode == 0) begin
        pulse_clear();
        run_tick(13'h1A0, 1'b1, 1'b0, 0);
      end else begin
        run_tick(13'h1A0, 1'b1, 1'b0, 2);
      end
      checks++;
      if (obs_upd_sig !== 1 || obs_vec !== exp_vec()) begin
        errors++;
        $display("FAIL clear_mode%0d: upd %0d out %h expected upd 1 out %h",
                 mode, obs_upd_sig, obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard, seen;
    do_reset();
    run_tick(13'h190, 1'b1, 1'b0, 0);
    @(negedge clk);
    temp_in = 13'h1A0; temp_rdy = 1'b1; temp_err = 1'b0;
    guard = 0;
    while (tb_cnt != SC - 1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    reset_n = 1'b0; temp_rdy = 1'b0;
    @(negedge clk);
    model_reset();
    checks++;
    if (dut_vec() !== exp_vec() || upd !== 1'b0 || guard >= 40) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %h upd %b expected %h upd 0", dut_vec(), upd, exp_vec());
    end
    reset_n = 1'b1;
    seen = 0;
    repeat (2 * SC) begin
      @(negedge clk);
      if (upd !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_mid_quiet: upd pulses %0d out %h expected 0 pulses out %h", seen, dut_vec(), exp_vec());
    end
    run_tick(13'h00A0, 1'b1, 1'b0, 0);
    checks++;
    if (obs_upd_sig !== 1 || obs_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_mid_restart: upd %0d out %h expected upd 1 out %h", obs_upd_sig, obs_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    logic [12:0] s;
    bit rdy, err;
    int clr;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      s = 13'($urandom_range(0, 8191));
      if ((i % 20) >= 15 && (i % 20) <= 18) begin
        rdy = 1'b1; err = 1'b1;
      end else begin
        rdy = ($urandom_range(0, 4) != 0);
        err = ($urandom_range(0, 5) == 0);
      end
      clr = $urandom_range(0, 4);
      if (clr > 2) clr = 0;
      run_tick(s, rdy, err, clr);
      checks++;
      if (obs_upd_sig !== (exp_upd ? 1 : 0) || obs_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random[%0d]: upd %0d out %h expected upd %0d out %h",
                 i, obs_upd_sig, obs_vec, exp_upd ? 1 : 0, exp_vec());
      end
      if ($urandom_range(0, 7) == 0) pulse_clear();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_step();
    test_negative();
    test_stale();
    test_clear();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
